// File: rtl/demux_sched.sv
// Stream scheduler for a 1x4 demux: holds one word and steers it to a channel
// chosen round-robin (skipping stalled consumers) or by a destination tag.
module demux_sched #(
  parameter int W       = 8,
  parameter int TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_dest,
  input  logic         mode,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   s,
  output logic         stall,
  output logic [7:0]   skip_cnt,
  output logic         dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready, while in_ready
  // depends combinationally on out_ready[s] so a word can leave and the next
  // one enter in the same cycle.

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] TO    = 8'(TIMEOUT);
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   s_q, s_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [7:0]   wait_q, wait_d;
  logic [7:0]   skip_q, skip_d;
  logic         mode_q, mode_d;
  logic         fire, load;

  assign fire     = (state_q == SEND) && out_ready[s_q];
  assign in_ready = (state_q == IDLE) || fire;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      s_q     <= 2'd0;
      ptr_q   <= 2'd0;
      wait_q  <= 8'd0;
      skip_q  <= 8'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      skip_q  <= skip_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    skip_d  = skip_q;
    mode_d  = mode_q;

    if (fire) begin
      state_d = IDLE;
      ptr_d   = s_q + 2'd1;
      wait_d  = 8'd0;
    end

    if (load) begin
      state_d = SEND;
      data_d  = in_data;
      mode_d  = mode;
      wait_d  = 8'd0;
      if (mode) s_d = in_dest;
      else      s_d = fire ? (s_q + 2'd1) : ptr_q;
    end else if ((state_q == SEND) && !fire) begin
      // Held word not taken: round-robin words hop to the next channel after
      // TIMEOUT cycles, directed words stay put and raise stall instead.
      if (!mode_q) begin
        if (wait_q == TO_M1) begin
          s_d    = s_q + 2'd1;
          wait_d = 8'd0;
          if (skip_q != 8'hFF) skip_d = skip_q + 8'd1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end else if (wait_q != TO) begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  assign out_valid = (state_q == SEND) ? (4'b0001 << s_q) : 4'b0000;
  assign out_data  = data_q;
  assign s         = s_q;
  assign stall     = (state_q == SEND) && mode_q && (wait_q == TO);
  assign skip_cnt  = skip_q;
  assign dbg_state = (state_q == SEND);

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched: round-robin, timeout skip, directed stall,
// back-to-back directed words and asynchronous reset mid-transfer.
module tb_demux_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       mode;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] s;
  logic       stall;
  logic [7:0] skip_cnt;
  logic       dbg_state;

  int checks   = 0;
  int failures = 0;

  demux_sched #(.W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .s(s), .stall(stall), .skip_cnt(skip_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dest   = 2'd0;
    mode      = 1'b0;
    out_ready = 4'b0000;

    // 1: reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_skip", 32'(skip_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 2: round-robin back-to-back, all ready
    mode      = 1'b0;
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + i);
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk("rr_valid", 32'(out_valid), 32'(1) << ((i - 1) % 4));
        chk("rr_data", 32'(out_data), 32'(8'hA1 + i - 1));
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("rr_last_valid", 32'(out_valid), 32'h1);
    chk("rr_last_data", 32'(out_data), 32'hA5);
    cyc();
    #1;
    chk("rr_idle_valid", 32'(out_valid), 32'h0);

    // 3: round-robin timeout skip past non-ready channel 1
    rst = 1'b1;
    #1 rst = 1'b0;
    cyc();
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_data   = 8'hB0;
    #1;
    chk("skip_load_ready", 32'(in_ready), 32'd1);
    cyc();
    in_data = 8'hB1;
    #1;
    chk("skip_b0_valid", 32'(out_valid), 32'h1);
    chk("skip_b0_data", 32'(out_data), 32'hB0);
    chk("skip_b0_fire", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("skip_wait_valid", 32'(out_valid), 32'h2);
      chk("skip_wait_s", 32'(s), 32'd1);
      chk("skip_wait_ready", 32'(in_ready), 32'd0);
      chk("skip_wait_cnt", 32'(skip_cnt), 32'd0);
      cyc();
    end
    in_valid = 1'b1;
    in_data  = 8'hB2;
    #1;
    chk("skip_s2", 32'(s), 32'd2);
    chk("skip_valid2", 32'(out_valid), 32'h4);
    chk("skip_data_b1", 32'(out_data), 32'hB1);
    chk("skip_cnt1", 32'(skip_cnt), 32'd1);
    chk("skip_fire2", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("skip_next_valid", 32'(out_valid), 32'h8);
    chk("skip_next_data", 32'(out_data), 32'hB2);
    cyc();

    // 4: directed word to blocked channel 3, stall after TIMEOUT waited cycles
    mode      = 1'b1;
    in_dest   = 2'd3;
    in_data   = 8'hC3;
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    #1;
    chk("dir_load_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    mode     = 1'b0;
    in_dest  = 2'd0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("dir_valid", 32'(out_valid), 32'h8);
      chk("dir_s", 32'(s), 32'd3);
      chk("dir_ready", 32'(in_ready), 32'd0);
      // stall once four full cycles have elapsed unserved
      chk("dir_stall", 32'(stall), 32'(k >= 4));
      cyc();
    end
    chk("dir_skip_unchanged", 32'(skip_cnt), 32'd1);
    out_ready = 4'b1111;
    #1;
    chk("dir_fire_ready", 32'(in_ready), 32'd1);
    chk("dir_data", 32'(out_data), 32'hC3);
    cyc();
    #1;
    chk("dir_stall_clear", 32'(stall), 32'd0);
    chk("dir_idle_valid", 32'(out_valid), 32'h0);

    // 5: two directed words to channel 2, ready 1,0,1
    mode      = 1'b1;
    in_dest   = 2'd2;
    in_data   = 8'hE1;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    cyc();
    out_ready = 4'b0100;
    in_data   = 8'hE2;
    #1;
    chk("b2b_e1_valid", 32'(out_valid), 32'h4);
    chk("b2b_e1_data", 32'(out_data), 32'hE1);
    chk("b2b_e1_fire", 32'(in_ready), 32'd1);
    cyc();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    chk("b2b_e2_valid", 32'(out_valid), 32'h4);
    chk("b2b_e2_data", 32'(out_data), 32'hE2);
    chk("b2b_e2_block", 32'(in_ready), 32'd0);
    cyc();
    out_ready = 4'b0100;
    #1;
    chk("b2b_e2_held", 32'(out_data), 32'hE2);
    chk("b2b_e2_fire", 32'(in_ready), 32'd1);
    cyc();
    #1;
    chk("b2b_no_dup", 32'(out_valid), 32'h0);

    // 6: async reset while 0xD5 is held on channel 1
    mode      = 1'b1;
    in_dest   = 2'd1;
    in_data   = 8'hD5;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("ar_pre_valid", 32'(out_valid), 32'h2);
    chk("ar_pre_data", 32'(out_data), 32'hD5);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_data", 32'(out_data), 32'h0);
    chk("ar_s", 32'(s), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_skip", 32'(skip_cnt), 32'd0);
    #1 rst = 1'b0;
    cyc();
    mode      = 1'b0;
    out_ready = 4'b1111;
    in_data   = 8'hD6;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    chk("ar_next_valid", 32'(out_valid), 32'h1);
    chk("ar_next_data", 32'(out_data), 32'hD6);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
